// File: rtl/shared_reg_pkg.sv
// Shared types and default parameters for the shared register arbiter.
package shared_reg_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1, wrapping modulo N_REQ.
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    last,
    output logic             any,
    output logic [PW-1:0]    winner
);

    // cand[k] is the requester examined at scan position k (k=0 is last+1).
    logic [PW-1:0] cand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = PW'((32'(last) + 32'(gi) + 32'd1) % 32'(N_REQ));
        end
    endgenerate

    // Scan from the far end back so the nearest candidate overwrites the rest.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                any    = 1'b1;
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared data register.
// A transaction is GRANT (1 cycle) then HOLD (HOLD_CYCLES cycles); the
// pointer last_reg remembers the most recent winner, even if it withdrew.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_t            state_reg, state_next;
    logic [PW-1:0]     last_reg,  last_next;
    logic [N_REQ-1:0]  grant_reg, grant_next;
    logic [N_REQ-1:0]  ack_reg,   ack_next;
    logic [WIDTH-1:0]  q_reg,     q_next;
    logic [CW-1:0]     cnt_reg,   cnt_next;
    logic              busy_reg,  busy_next;

    logic              pick_any;
    logic [PW-1:0]     pick_winner;
    logic [WIDTH-1:0]  wdata_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_wdata
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req    (req),
        .last   (last_reg),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Next-state and output decode; during GRANT/HOLD the owner is last_reg.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        grant_next = grant_reg;
        ack_next   = '0;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_next = ONE << pick_winner;
                    last_next  = pick_winner;
                    state_next = GRANT;
                end else begin
                    grant_next = '0;
                end
            end
            GRANT: begin
                if (req[last_reg]) begin
                    q_next     = wdata_arr[last_reg];
                    ack_next   = ONE << last_reg;
                    cnt_next   = CW'(HOLD_CYCLES - 1);
                    state_next = HOLD;
                end else begin
                    grant_next = '0;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    grant_next = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and registered outputs; reset clears everything, including q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            last_reg  <= PW'(N_REQ - 1);
            grant_reg <= '0;
            ack_reg   <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
            ack_reg   <= ack_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
        end
    end

    assign grant = grant_reg;
    assign ack   = ack_reg;
    assign q     = q_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_shared_reg_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HOLD = 2;

    logic             clock;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   wdata;
    logic [N-1:0]     grant;
    logic [N-1:0]     ack;
    logic [W-1:0]     q;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    int          got_order[$];
    logic [W-1:0] got_q[$];

    shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .grant (grant),
        .ack   (ack),
        .q     (q),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // owner = -1 when idle; age 0 = grant cycle, 1..HOLD = hold cycles.
    int           m_owner;
    int           m_age;
    int           m_last;
    logic [W-1:0] m_q;

    function automatic int rr_first(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_owner <= -1;
            m_age   <= 0;
            m_last  <= N - 1;
            m_q     <= '0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                m_owner <= rr_first(req, m_last);
                m_last  <= rr_first(req, m_last);
                m_age   <= 0;
            end
        end else if (m_age == 0) begin
            if (req[m_owner]) begin
                m_q   <= wdata[m_owner*W +: W];
                m_age <= 1;
            end else begin
                m_owner <= -1;
            end
        end else if (m_age == HOLD) begin
            m_owner <= -1;
        end else begin
            m_age <= m_age + 1;
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clock) begin
        if (reset) begin
            chk("model_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("model_ack",   32'(ack),   (m_owner >= 0 && m_age == 1) ? (32'd1 << m_owner) : 32'd0);
            chk("model_q",     32'(q),     32'(m_q));
            chk("model_busy",  32'(busy),  (m_owner >= 0) ? 32'd1 : 32'd0);
        end
    end

    // ---------------- directed helpers ----------------
    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int ord_at(input int i);
        if (i < got_order.size()) return got_order[i];
        return 99;
    endfunction

    function automatic logic [W-1:0] q_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hEE;
    endfunction

    // Run requesters until all are served: each drops its req on seeing ack.
    task automatic serve(input int max_cycles);
        logic [N-1:0] prev;
        int n;
        prev = grant;
        n = 0;
        got_order.delete();
        got_q.delete();
        while (n < max_cycles && (req != 0 || busy)) begin
            @(negedge clock);
            n++;
            if (grant != 0 && grant != prev) got_order.push_back(idx_of(grant));
            prev = grant;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                    got_q.push_back(q);
                end
            end
        end
        chk("serve_done", 32'(req == 0 && !busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        wdata = '0;
        repeat (2) @(negedge clock);
        chk("por_grant", 32'(grant), 32'd0);
        chk("por_ack",   32'(ack),   32'd0);
        chk("por_q",     32'(q),     32'd0);
        chk("por_busy",  32'(busy),  32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single write from requester 2
        wdata[2*W +: W] = 8'h3C;
        req = 4'b0100;
        @(negedge clock);
        chk("sw_grant_e0", 32'(grant), 32'h4);
        chk("sw_busy_e0",  32'(busy),  32'd1);
        chk("sw_q_e0",     32'(q),     32'h00);
        @(negedge clock);
        chk("sw_q_e1",     32'(q),     32'h3C);
        chk("sw_ack_e1",   32'(ack),   32'h4);
        req = 4'b0000;
        @(negedge clock);
        chk("sw_ack_e2",   32'(ack),   32'h0);
        chk("sw_grant_e2", 32'(grant), 32'h4);
        chk("sw_busy_e2",  32'(busy),  32'd1);
        @(negedge clock);
        chk("sw_grant_e3", 32'(grant), 32'h0);
        chk("sw_busy_e3",  32'(busy),  32'd0);

        // Reset in the middle of HOLD with q = A5
        wdata[1*W +: W] = 8'hA5;
        req = 4'b0010;
        @(negedge clock);
        chk("rst_grant_pre", 32'(grant), 32'h2);
        @(negedge clock);
        chk("rst_q_pre", 32'(q), 32'hA5);
        #2 reset = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_q",     32'(q),     32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Fairness from a fresh pointer: 0,1,2,3
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        serve(100);
        chk("fair_count", 32'(got_order.size()), 32'd4);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("fair_order%0d", i), 32'(ord_at(i)), 32'(i));
            chk($sformatf("fair_q%0d", i), 32'(q_at(i)), 32'((i + 1) * 8'h11));
        end

        // Wrap-around after requester 3 won
        req = 4'b1001;
        serve(100);
        chk("wrap_first",  32'(ord_at(0)), 32'd0);
        chk("wrap_second", 32'(ord_at(1)), 32'd3);
        chk("wrap_q_last", 32'(q), 32'h44);

        // Withdrawal of requester 1 during GRANT
        req = 4'b0010;
        @(negedge clock);
        chk("wd_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        @(negedge clock);
        chk("wd_grant_clr", 32'(grant), 32'h0);
        chk("wd_ack",       32'(ack),   32'h0);
        chk("wd_busy",      32'(busy),  32'd0);
        chk("wd_q",         32'(q),     32'h44);
        req = 4'b0011;
        serve(100);
        chk("wd_next0", 32'(ord_at(0)), 32'd0);
        chk("wd_next1", 32'(ord_at(1)), 32'd1);
        chk("wd_q0",    32'(q_at(0)),   32'h11);

        // Changes during HOLD are ignored
        wdata[2*W +: W] = 8'h5A;
        req = 4'b0100;
        @(negedge clock);
        chk("ih_grant_e0", 32'(grant), 32'h4);
        @(negedge clock);
        chk("ih_ack_e1", 32'(ack), 32'h4);
        chk("ih_q_e1",   32'(q),   32'h5A);
        wdata[2*W +: W] = 8'hFF;
        req = 4'b1011;
        @(negedge clock);
        chk("ih_grant_e2", 32'(grant), 32'h4);
        chk("ih_q_e2",     32'(q),     32'h5A);
        @(negedge clock);
        chk("ih_grant_e3", 32'(grant), 32'h0);
        chk("ih_q_e3",     32'(q),     32'h5A);
        serve(100);
        chk("ih_order0", 32'(ord_at(0)), 32'd3);
        chk("ih_order1", 32'(ord_at(1)), 32'd0);
        chk("ih_order2", 32'(ord_at(2)), 32'd1);
        chk("ih_q_final", 32'(q), 32'h22);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
